// File: rtl/tdm_demux4.sv
// tdm_demux4 - four-slot time-division demultiplexer.
//
// Receive end of a 4:1 serialiser lane. Each accepted beat is steered into a
// slot by a frame-synchronised slot counter. When the slot-3 beat arrives, the
// complete frame is published on o with a one-cycle frame_valid strobe. Loss of
// framing is flagged on err and recovered automatically at the next sof beat.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous reset, active high
//   din[W]       serial lane data, one slot per accepted beat
//   din_valid    beat qualifier
//   sof          start-of-frame, marks the beat as slot 0 (only with din_valid)
//   o[4W]        last complete frame, slot k at o[W*k +: W]
//   frame_valid  one-cycle pulse, o has just been updated
//   sel[2]       slot that the next accepted beat will be written to
//   locked       high while frame sync is held
//   err          one-cycle pulse on a framing error
//
// state  | meaning
// -------+-----------------------------------------------------------
// HUNT   | no frame sync; sof=0 beats are dropped, a sof beat locks
// LOCKED | slot counter valid; beats fill slots 0..3 in order

module tdm_demux4 #(
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   din,
    input  logic           din_valid,
    input  logic           sof,
    output logic [4*W-1:0] o,
    output logic           frame_valid,
    output logic [1:0]     sel,
    output logic           locked,
    output logic           err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           sel_q, sel_d;
    logic [2:0][W-1:0]    shadow_q, shadow_d;
    logic [4*W-1:0]       o_q, o_d;
    logic                 fv_q, fv_d;
    logic                 err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HUNT;
            sel_q    <= 2'd0;
            shadow_q <= '0;
            o_q      <= '0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            o_q      <= o_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        shadow_d = shadow_q;
        o_d      = o_q;
        fv_d     = 1'b0;
        err_d    = 1'b0;

        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (sof) begin
                        shadow_d[0] = din;
                        sel_d       = 2'd1;
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sof) begin
                        // An sof beat always restarts the frame; only an sof
                        // arriving mid-frame is a framing error.
                        err_d       = (sel_q != 2'd0);
                        shadow_d[0] = din;
                        sel_d       = 2'd1;
                    end else begin
                        case (sel_q)
                            2'd0: begin
                                err_d   = 1'b1;
                                sel_d   = 2'd0;
                                state_d = HUNT;
                            end
                            2'd1: begin
                                shadow_d[1] = din;
                                sel_d       = 2'd2;
                            end
                            2'd2: begin
                                shadow_d[2] = din;
                                sel_d       = 2'd3;
                            end
                            default: begin
                                // Slot 3 goes straight to the output word.
                                o_d   = {din, shadow_q[2], shadow_q[1], shadow_q[0]};
                                fv_d  = 1'b1;
                                sel_d = 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = HUNT;
                    sel_d   = 2'd0;
                end
            endcase
        end
    end

    assign o           = o_q;
    assign frame_valid = fv_q;
    assign sel         = sel_q;
    assign locked      = (state_q == LOCKED);
    assign err         = err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;

    logic        clk = 1'b0;
    logic        rst;
    logic        din_valid;
    logic        sof;
    logic [3:0]  din4;
    logic [0:0]  din1;

    logic [15:0] o4;
    logic        fv4, err4, lk4;
    logic [1:0]  sel4;
    logic [3:0]  o1;
    logic        fv1, err1, lk1;
    logic [1:0]  sel1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;
    assign din1 = din4[0:0];

    tdm_demux4 #(.W(4)) u_dut4 (
        .clk(clk), .rst(rst), .din(din4), .din_valid(din_valid), .sof(sof),
        .o(o4), .frame_valid(fv4), .sel(sel4), .locked(lk4), .err(err4)
    );

    tdm_demux4 #(.W(1)) u_dut1 (
        .clk(clk), .rst(rst), .din(din1), .din_valid(din_valid), .sof(sof),
        .o(o1), .frame_valid(fv1), .sel(sel1), .locked(lk1), .err(err1)
    );

    // Reference model: frame sync flag, beats gathered so far in the current
    // frame, and the last published frame (4 bits per slot).
    bit          m_locked;
    logic [3:0]  m_beats[$];
    logic [15:0] m_o;
    bit          m_fv, m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_beats.delete();
        m_o   = '0;
        m_fv  = 0;
        m_err = 0;
    endtask

    task automatic model_step(input bit v, input bit s, input logic [3:0] d);
        m_fv  = 0;
        m_err = 0;
        if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_locked = 1;
                    m_beats.delete();
                    m_beats.push_back(d);
                end
            end else if (s) begin
                if (m_beats.size() != 0) m_err = 1;
                m_beats.delete();
                m_beats.push_back(d);
            end else if (m_beats.size() == 0) begin
                m_err    = 1;
                m_locked = 0;
            end else begin
                m_beats.push_back(d);
                if (m_beats.size() == 4) begin
                    m_o = {m_beats[3], m_beats[2], m_beats[1], m_beats[0]};
                    m_fv = 1;
                    m_beats.delete();
                end
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] exp_o1;
        int         exp_sel;
        exp_o1  = {m_o[12], m_o[8], m_o[4], m_o[0]};
        exp_sel = m_locked ? m_beats.size() : 0;
        chk("o_w4", o4, m_o);
        chk("o_w1", o1, exp_o1);
        chk("fv_w4", fv4, m_fv);
        chk("fv_w1", fv1, m_fv);
        chk("err_w4", err4, m_err);
        chk("err_w1", err1, m_err);
        chk("sel_w4", sel4, exp_sel);
        chk("sel_w1", sel1, exp_sel);
        chk("locked_w4", lk4, m_locked);
        chk("locked_w1", lk1, m_locked);
        chk("fv_err_excl", fv4 & err4, 0);
    endtask

    task automatic beat(input bit v, input bit s, input logic [3:0] d);
        din_valid = v;
        sof       = s;
        din4      = d;
        @(posedge clk);
        model_step(v, s, d);
        #1;
        check_all();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        din_valid = 1'b0;
        sof       = 1'b0;
        din4      = '0;
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic frame then three back-to-back frames, W=1 view on bit 0.
        beat(1, 1, 4'h1); beat(1, 0, 4'h0); beat(1, 0, 4'h0); beat(1, 0, 4'h0);
        chk("frame1_o1", o1, 4'b0001);
        beat(1, 1, 4'h0); beat(1, 0, 4'h1); beat(1, 0, 4'h0); beat(1, 0, 4'h0);
        chk("frame2_o1", o1, 4'b0010);
        beat(1, 1, 4'h0); beat(1, 0, 4'h0); beat(1, 0, 4'h1); beat(1, 0, 4'h0);
        chk("frame3_o1", o1, 4'b0100);
        beat(1, 1, 4'h0); beat(1, 0, 4'h0); beat(1, 0, 4'h0); beat(1, 0, 4'h1);
        chk("frame4_o1", o1, 4'b1000);

        // Idle cycles interleaved inside a frame.
        beat(1, 1, 4'h1); beat(0, 1, 4'h0); beat(1, 0, 4'h0); beat(0, 0, 4'h1);
        beat(1, 0, 4'h1); beat(0, 1, 4'h0); beat(1, 0, 4'h1);
        chk("idle_o1", o1, 4'b1101);

        // Early sof on slot 2, then the new frame completes.
        beat(1, 1, 4'h0); beat(1, 0, 4'h1); beat(1, 1, 4'h1);
        chk("early_sof_err", err1, 1);
        chk("early_sof_o1", o1, 4'b1101);
        beat(1, 0, 4'h0); beat(1, 0, 4'h1); beat(1, 0, 4'h1);
        chk("relock_o1", o1, 4'b1101);

        // Missing sof: drop to HUNT, discard silently, relock on sof.
        beat(1, 0, 4'h1);
        chk("missing_sof_locked", lk1, 0);
        beat(1, 0, 4'h1); beat(1, 0, 4'h0);
        beat(1, 1, 4'hA);
        chk("hunt_relock", lk4, 1);

        // Wide slots: A,5,3,C.
        beat(1, 0, 4'h5); beat(1, 0, 4'h3); beat(1, 0, 4'hC);
        chk("w4_frame", o4, 16'hC35A);
        chk("w4_frame_o1", o1, 4'b0110);

        // Reset mid-frame.
        beat(1, 1, 4'h7); beat(1, 0, 4'h9);
        pulse_reset();
        chk("rst_o4", o4, 16'h0);
        beat(1, 0, 4'h3); beat(1, 0, 4'h3); beat(1, 0, 4'h3);
        beat(1, 1, 4'h2); beat(1, 0, 4'h4); beat(1, 0, 4'h6); beat(1, 0, 4'h8);
        chk("post_rst_frame", o4, 16'h8642);

        // Randomised traffic: mostly well-framed with occasional sof faults.
        begin
            int slot = 0;
            for (int i = 0; i < 3000; i++) begin
                bit v, s;
                v = ($urandom_range(0, 3) != 0);
                s = (slot == 0);
                if ($urandom_range(0, 15) == 0) s = ~s;
                if (v) slot = s ? 1 : (slot + 1) % 4;
                beat(v, s, 4'($urandom));
                if ($urandom_range(0, 499) == 0) begin
                    pulse_reset();
                    slot = 0;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
